// File: rtl/xbar_pkg.sv
// Shared types for the crossbar arbiters.
package xbar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } bwd_arb_state_t;

endpackage

// File: rtl/rotate_priority_picker.sv
// Combinational rotating-priority picker: first set request at or above
// ptr, wrapping from width-1 back to 0.
module rotate_priority_picker #(
    parameter  int width = 2,
    localparam int idx_w = (width > 1) ? $clog2(width) : 1
) (
    input  logic [width-1:0] req,
    input  logic [idx_w-1:0] ptr,
    output logic [idx_w-1:0] pick,
    output logic             any
);

    logic [idx_w:0] idx;

    // One extra index bit lets ptr+k exceed width before the explicit wrap,
    // which keeps non-power-of-2 widths correct.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 0; k < width; k++) begin
            idx = {1'b0, ptr} + (idx_w+1)'(k);
            if (idx >= (idx_w+1)'(width)) begin
                idx = idx - (idx_w+1)'(width);
            end
            if (!any && req[idx[idx_w-1:0]]) begin
                pick = idx[idx_w-1:0];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/backward_arbiter.sv
// Per-master response arbiter: locks one slave FIFO for a whole burst,
// then rotates round-robin priority past the finished slave.
module backward_arbiter
    import xbar_pkg::*;
#(
    parameter  int masters            = 2,
    parameter  int slaves             = 2,
    parameter  int i_am_master_number = 0,
    localparam int mw                 = $clog2(masters),
    localparam int sw                 = $clog2(slaves)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [slaves-1:0] slave_fifo_empty,
    input  logic [mw-1:0]     slave_master_dest [0:slaves-1],
    input  logic [slaves-1:0] slave_resp_last,
    input  logic              master_resp_ready,
    output logic              master_resp_valid,
    output logic              grant_valid,
    output logic [sw-1:0]     grant_slave_number,
    output logic [slaves-1:0] slave_fifo_pop
);

    bwd_arb_state_t    state;
    bwd_arb_state_t    next_state;
    logic [sw-1:0]     rr_ptr;
    logic [slaves-1:0] req;
    logic [sw-1:0]     pick;
    logic              any;
    logic              beat;
    logic              done;

    always_comb begin
        req = '0;
        for (int i = 0; i < slaves; i++) begin
            req[i] = ~slave_fifo_empty[i] &
                     (slave_master_dest[i] == mw'(i_am_master_number));
        end
    end

    rotate_priority_picker #(
        .width (slaves)
    ) u_picker (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any)
    );

    assign beat = master_resp_valid & master_resp_ready;
    assign done = beat & slave_resp_last[grant_slave_number];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            grant_slave_number <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && any) begin
                grant_slave_number <= pick;
            end
            // Priority moves only when a burst completes, never on a pick.
            if (done) begin
                rr_ptr <= (grant_slave_number == sw'(slaves - 1))
                          ? '0 : grant_slave_number + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (any) next_state = BURST;
            BURST:   if (done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_valid       = 1'b0;
        master_resp_valid = 1'b0;
        slave_fifo_pop    = '0;
        if (state == BURST) begin
            grant_valid       = 1'b1;
            master_resp_valid = ~slave_fifo_empty[grant_slave_number];
            slave_fifo_pop[grant_slave_number] =
                ~slave_fifo_empty[grant_slave_number] & master_resp_ready;
        end
    end

endmodule
